alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  Decode stage to ALU issue register. Decodes a 32-bit RV32I instruction into ALU operand-select
//  and operation controls (ALUASrc/ALUBSrc/ALUCtl), then registers them into the ID/EX boundary.
//  Uses a valid/ready handshake with stall and flush. Sits between fetch/decode and the EX-stage ALU.
// PARAMETERS
//  PC_W   32   width of pc_in/pc_out
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  flush      in   1     kill issue slot (branch/jump redirect)
//  in_valid   in   1     instr/pc_in valid from decode
//  in_ready   out  1     stage can accept this cycle
//  instr      in   32    raw instruction
//  pc_in      in   PC_W  instruction address
//  out_valid  out  1     registered controls valid to EX
//  out_ready  in   1     EX consumes this cycle
//  ALUASrc    out  1     1=pc, 0=ReadData1
//  ALUBSrc    out  2     00=ReadData2, 01=ImmGenOut, 10=const 4, 11 unused
//  ALUCtl     out  4     ALU operation code (table below)
//  is_branch  out  1     conditional branch; br_funct3 valid
//  br_funct3  out  3     instr[14:12] of branch
//  pc_out     out  PC_W  registered pc_in
//  illegal    out  1     undecodable instruction (see CONFIGURATION)
// BEHAVIOUR
//  - ALUCtl codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 1010, XOR 0100, SRL 0101,
//    SRA 1101, OR 0110, AND 0111, LOADIMM 0011. Decode is explicit (SLTU != {f7[5],f3}).
//  - OP (0110011): B=00. f3 selects op; f7[5]=1 with f3=000 -> SUB, with f3=101 -> SRA.
//  - OP-IMM (0010011): B=01. Same mapping, SUB never produced. SRAI when instr[30]=1, f3=101.
//  - LOAD/STORE: ADD, A=0, B=01.  LUI: LOADIMM, B=01.  AUIPC: ADD, A=1, B=01.
//  - JAL/JALR: ADD, A=1, B=10 (link value pc+4).
//  - BRANCH: B=00, is_branch=1. BEQ/BNE -> SUB, BLT/BGE -> SLT, BLTU/BGEU -> SLTU.
//  - FENCE/SYSTEM/unknown opcode: ADD, A=0, B=00.
//  - Handshake: in_ready = !out_valid | out_ready (combinational, no skid buffer).
//  - Accept = in_valid & in_ready & !flush. The stage loads decoded controls and pc_out, and
//    out_valid<=1. Latency is exactly 1 cycle.
//  - If in_ready is high but no accept occurs, out_valid<=0.
//  - Stall (out_valid & !out_ready): all outputs hold their values.
//  - flush has priority. out_valid<=0 next edge, any input offered in the same cycle is dropped,
//    and data registers may hold stale values.
//  - Reset (asynchronous, any time, including mid-stall): out_valid=0, ALUASrc=0, ALUBSrc=00,
//    ALUCtl=0000, is_branch=0, br_funct3=0, pc_out=0, illegal=0.
//  - Outputs when out_valid=0 carry no meaning. EX must gate on out_valid.
// CONFIGURATION
//  ALU_CTRL_ILLEGAL_CHECK_EN
//   - Defined: illegal=1 is registered with the instruction for any of:
//       - unknown opcode
//       - instr[1:0]!=11
//       - OP with f7 not in {0000000, 0100000}
//       - f7=0100000 with f3 not in {000, 101}
//       - SLLI/SRLI/SRAI with bad imm[11:5]
//       - BRANCH f3 in {010, 011}
//     Controls for such instructions are forced to ADD/A=0/B=00.
//   - Undefined: illegal is tied to 0. Decode ignores funct7 except bit 5, and ignores the
//     rule checks above.
// TESTING
//  1. 0x002081B3 (add), out_ready=1 -> next cycle out_valid=1, ALUCtl=0000, ALUASrc=0, ALUBSrc=00.
//  2. 0x0010B193 (sltiu), then 0x4040D193 (srai) -> ALUCtl=1010 then 1101, ALUBSrc=01.
//     Back-to-back issue, one per cycle.
//  3. 0x008000EF (jal) -> ALUASrc=1, ALUBSrc=10, ALUCtl=0000.
//     0x00208463 (beq) -> is_branch=1, ALUCtl=1000.
//  4. out_valid=1, out_ready=0 for 3 cycles with next instr offered -> in_ready=0 and outputs
//     held. Release -> held instr consumed, new instr appears 1 cycle later, none lost or duplicated.
//  5. flush=1 with in_valid=1 -> next cycle out_valid=0. Flush during stall also clears out_valid.
//  6. rst pulsed mid-stall -> out_valid and ALUCtl reach 0 before the next clk edge.
//     With EN, 0x0000007F -> illegal=1.

Source files
------------

// File: rtl/alu_ctrl_issue_if.sv
// ============================================================================
// Module   : alu_ctrl_issue_if
// Brief    : Decode-to-EX issue bus carrying instruction, pc and ALU controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_ctrl_issue_if #(
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic            ALUASrc;
    logic [1:0]      ALUBSrc;
    logic [3:0]      ALUCtl;
    logic            is_branch;
    logic [2:0]      br_funct3;
    logic [PC_W-1:0] pc_out;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, pc_in, out_ready,
        input  in_ready, out_valid, ALUASrc, ALUBSrc, ALUCtl,
               is_branch, br_funct3, pc_out, illegal
    );

    modport slave (
        input  flush, in_valid, instr, pc_in, out_ready,
        output in_ready, out_valid, ALUASrc, ALUBSrc, ALUCtl,
               is_branch, br_funct3, pc_out, illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_issue.sv
// ============================================================================
// Module   : alu_ctrl_issue
// Brief    : RV32I decode to ALU controls, registered into the ID/EX slot.
//            Optional legality checking via ALU_CTRL_ILLEGAL_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_issue #(
    parameter int PC_W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    alu_ctrl_issue_if.slave   bus
);
    localparam logic [3:0] c_add  = 4'b0000;
    localparam logic [3:0] c_sub  = 4'b1000;
    localparam logic [3:0] c_sll  = 4'b0001;
    localparam logic [3:0] c_slt  = 4'b0010;
    localparam logic [3:0] c_sltu = 4'b1010;
    localparam logic [3:0] c_xor  = 4'b0100;
    localparam logic [3:0] c_srl  = 4'b0101;
    localparam logic [3:0] c_sra  = 4'b1101;
    localparam logic [3:0] c_or   = 4'b0110;
    localparam logic [3:0] c_and  = 4'b0111;
    localparam logic [3:0] c_limm = 4'b0011;

    localparam logic [6:0] c_op_reg = 7'b0110011;
    localparam logic [6:0] c_op_imm = 7'b0010011;
    localparam logic [6:0] c_load   = 7'b0000011;
    localparam logic [6:0] c_store  = 7'b0100011;
    localparam logic [6:0] c_lui    = 7'b0110111;
    localparam logic [6:0] c_auipc  = 7'b0010111;
    localparam logic [6:0] c_jal    = 7'b1101111;
    localparam logic [6:0] c_jalr   = 7'b1100111;
    localparam logic [6:0] c_branch = 7'b1100011;

    localparam logic [1:0] c_b_rs2  = 2'b00;
    localparam logic [1:0] c_b_imm  = 2'b01;
    localparam logic [1:0] c_b_four = 2'b10;

    // alt is funct7[5] / instr[30]; OP-IMM never turns ADD into SUB.
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
        logic [3:0] r;
        case (f3)
            3'b000:  r = (alt && allow_sub) ? c_sub : c_add;
            3'b001:  r = c_sll;
            3'b010:  r = c_slt;
            3'b011:  r = c_sltu;
            3'b100:  r = c_xor;
            3'b101:  r = alt ? c_sra : c_srl;
            3'b110:  r = c_or;
            default: r = c_and;
        endcase
        return r;
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [3:0] w_ctl;
    logic       w_asrc;
    logic [1:0] w_bsrc;
    logic       w_br;
    logic [2:0] w_brf3;
    logic       w_accept;

    assign w_opcode = bus.instr[6:0];
    assign w_f3     = bus.instr[14:12];
    assign w_accept = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        w_ctl  = c_add;
        w_asrc = 1'b0;
        w_bsrc = c_b_rs2;
        w_br   = 1'b0;
        w_brf3 = 3'b000;
        case (w_opcode)
            c_op_reg: w_ctl = alu_op(w_f3, bus.instr[30], 1'b1);
            c_op_imm: begin
                w_ctl  = alu_op(w_f3, bus.instr[30], 1'b0);
                w_bsrc = c_b_imm;
            end
            c_load, c_store: w_bsrc = c_b_imm;
            c_lui: begin
                w_ctl  = c_limm;
                w_bsrc = c_b_imm;
            end
            c_auipc: begin
                w_asrc = 1'b1;
                w_bsrc = c_b_imm;
            end
            c_jal, c_jalr: begin
                w_asrc = 1'b1;
                w_bsrc = c_b_four;
            end
            c_branch: begin
                w_br   = 1'b1;
                w_brf3 = w_f3;
                case (w_f3[2:1])
                    2'b00:   w_ctl = c_sub;
                    2'b10:   w_ctl = c_slt;
                    2'b11:   w_ctl = c_sltu;
                    default: w_ctl = c_add;
                endcase
            end
            default: ;
        endcase
    end

    logic            r_out_valid;
    logic            r_asrc;
    logic [1:0]      r_bsrc;
    logic [3:0]      r_ctl;
    logic            r_br;
    logic [2:0]      r_brf3;
    logic [PC_W-1:0] r_pc;

`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
    logic [6:0] w_f7;
    logic       w_known;
    logic       w_ill;
    logic       r_illegal;

    assign w_f7 = bus.instr[31:25];

    always_comb begin
        w_known = 1'b0;
        case (w_opcode)
            c_op_reg, c_op_imm, c_load, c_store, c_lui, c_auipc,
            c_jal, c_jalr, c_branch, 7'b0001111, 7'b1110011: w_known = 1'b1;
            default: w_known = 1'b0;
        endcase
        w_ill = !w_known || (bus.instr[1:0] != 2'b11);
        if (w_opcode == c_op_reg) begin
            if ((w_f7 != 7'b0000000) && (w_f7 != 7'b0100000))
                w_ill = 1'b1;
            if ((w_f7 == 7'b0100000) && (w_f3 != 3'b000) && (w_f3 != 3'b101))
                w_ill = 1'b1;
        end
        if (w_opcode == c_op_imm) begin
            if ((w_f3 == 3'b001) && (w_f7 != 7'b0000000))
                w_ill = 1'b1;
            if ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000))
                w_ill = 1'b1;
        end
        if ((w_opcode == c_branch) && (w_f3[2:1] == 2'b01))
            w_ill = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_illegal <= 1'b0;
        else if (w_accept)
            r_illegal <= w_ill;
    end

    assign bus.illegal = r_illegal;
`else
    assign bus.illegal = 1'b0;
`endif

    // Flush beats everything; a stall (valid, not ready) simply holds all state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_asrc      <= 1'b0;
            r_bsrc      <= 2'b00;
            r_ctl       <= 4'b0000;
            r_br        <= 1'b0;
            r_brf3      <= 3'b000;
            r_pc        <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_pc        <= bus.pc_in;
`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
            r_asrc      <= w_ill ? 1'b0    : w_asrc;
            r_bsrc      <= w_ill ? c_b_rs2 : w_bsrc;
            r_ctl       <= w_ill ? c_add   : w_ctl;
            r_br        <= w_ill ? 1'b0    : w_br;
            r_brf3      <= w_ill ? 3'b000  : w_brf3;
`else
            r_asrc      <= w_asrc;
            r_bsrc      <= w_bsrc;
            r_ctl       <= w_ctl;
            r_br        <= w_br;
            r_brf3      <= w_brf3;
`endif
        end else if (bus.in_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.ALUASrc   = r_asrc;
    assign bus.ALUBSrc   = r_bsrc;
    assign bus.ALUCtl    = r_ctl;
    assign bus.is_branch = r_br;
    assign bus.br_funct3 = r_brf3;
    assign bus.pc_out    = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_issue.sv
// ============================================================================
// Module   : tb_alu_ctrl_issue
// Brief    : Directed and randomized checks of alu_ctrl_issue against a slot model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_issue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ctrl_issue_if #(.PC_W(32)) bus ();
    alu_ctrl_issue #(.PC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0]  ctl;
        logic        a;
        logic [1:0]  b;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
        logic [31:0] pc;
    } item_t;

`ifdef ALU_CTRL_ILLEGAL_CHECK_EN
    localparam logic c_ill_en = 1'b1;
`else
    localparam logic c_ill_en = 1'b0;
`endif

    int    checks   = 0;
    int    failures = 0;
    logic  m_valid  = 1'b0;
    item_t m_item;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic item_t mk(input logic [3:0] ctl, input logic a, input logic [1:0] b,
                                 input logic br, input logic [2:0] f3, input logic ill);
        item_t e;
        e.ctl = ctl; e.a = a; e.b = b; e.br = br; e.f3 = f3; e.ill = ill; e.pc = '0;
        return e;
    endfunction

    // Builds a random instruction of a random kind together with the controls it must produce.
    task automatic gen(output logic [31:0] ins, output item_t e);
        logic [4:0]  rd   = 5'($urandom);
        logic [4:0]  rs1  = 5'($urandom);
        logic [4:0]  rs2  = 5'($urandom);
        logic [11:0] imm  = 12'($urandom);
        logic [19:0] up   = 20'($urandom);
        logic [2:0]  rf3  = 3'($urandom);
        logic [6:0]  op;
        int k = $urandom_range(0, 27);
        int j;
        case (k)
            0:  begin ins = {7'h00, rs2, rs1, 3'd0, rd, 7'b0110011}; e = mk(4'b0000, 0, 2'b00, 0, 0, 0); end
            1:  begin ins = {7'h20, rs2, rs1, 3'd0, rd, 7'b0110011}; e = mk(4'b1000, 0, 2'b00, 0, 0, 0); end
            2:  begin ins = {7'h00, rs2, rs1, 3'd1, rd, 7'b0110011}; e = mk(4'b0001, 0, 2'b00, 0, 0, 0); end
            3:  begin ins = {7'h00, rs2, rs1, 3'd2, rd, 7'b0110011}; e = mk(4'b0010, 0, 2'b00, 0, 0, 0); end
            4:  begin ins = {7'h00, rs2, rs1, 3'd3, rd, 7'b0110011}; e = mk(4'b1010, 0, 2'b00, 0, 0, 0); end
            5:  begin ins = {7'h00, rs2, rs1, 3'd4, rd, 7'b0110011}; e = mk(4'b0100, 0, 2'b00, 0, 0, 0); end
            6:  begin ins = {7'h00, rs2, rs1, 3'd5, rd, 7'b0110011}; e = mk(4'b0101, 0, 2'b00, 0, 0, 0); end
            7:  begin ins = {7'h20, rs2, rs1, 3'd5, rd, 7'b0110011}; e = mk(4'b1101, 0, 2'b00, 0, 0, 0); end
            8:  begin ins = {7'h00, rs2, rs1, 3'd6, rd, 7'b0110011}; e = mk(4'b0110, 0, 2'b00, 0, 0, 0); end
            9:  begin ins = {7'h00, rs2, rs1, 3'd7, rd, 7'b0110011}; e = mk(4'b0111, 0, 2'b00, 0, 0, 0); end
            10: begin ins = {imm, rs1, 3'd0, rd, 7'b0010011}; e = mk(4'b0000, 0, 2'b01, 0, 0, 0); end
            11: begin ins = {imm, rs1, 3'd2, rd, 7'b0010011}; e = mk(4'b0010, 0, 2'b01, 0, 0, 0); end
            12: begin ins = {imm, rs1, 3'd3, rd, 7'b0010011}; e = mk(4'b1010, 0, 2'b01, 0, 0, 0); end
            13: begin ins = {imm, rs1, 3'd4, rd, 7'b0010011}; e = mk(4'b0100, 0, 2'b01, 0, 0, 0); end
            14: begin ins = {imm, rs1, 3'd6, rd, 7'b0010011}; e = mk(4'b0110, 0, 2'b01, 0, 0, 0); end
            15: begin ins = {imm, rs1, 3'd7, rd, 7'b0010011}; e = mk(4'b0111, 0, 2'b01, 0, 0, 0); end
            16: begin ins = {7'h00, rs2, rs1, 3'd1, rd, 7'b0010011}; e = mk(4'b0001, 0, 2'b01, 0, 0, 0); end
            17: begin ins = {7'h00, rs2, rs1, 3'd5, rd, 7'b0010011}; e = mk(4'b0101, 0, 2'b01, 0, 0, 0); end
            18: begin ins = {7'h20, rs2, rs1, 3'd5, rd, 7'b0010011}; e = mk(4'b1101, 0, 2'b01, 0, 0, 0); end
            19: begin ins = {imm, rs1, rf3, rd, 7'b0000011}; e = mk(4'b0000, 0, 2'b01, 0, 0, 0); end
            20: begin ins = {imm, rs1, rf3, rd, 7'b0100011}; e = mk(4'b0000, 0, 2'b01, 0, 0, 0); end
            21: begin ins = {up, rd, 7'b0110111}; e = mk(4'b0011, 0, 2'b01, 0, 0, 0); end
            22: begin ins = {up, rd, 7'b0010111}; e = mk(4'b0000, 1, 2'b01, 0, 0, 0); end
            23: begin ins = {up, rd, 7'b1101111}; e = mk(4'b0000, 1, 2'b10, 0, 0, 0); end
            24: begin ins = {imm, rs1, 3'd0, rd, 7'b1100111}; e = mk(4'b0000, 1, 2'b10, 0, 0, 0); end
            25: begin
                j = $urandom_range(0, 5);
                case (j)
                    0: rf3 = 3'b000;  1: rf3 = 3'b001;  2: rf3 = 3'b100;
                    3: rf3 = 3'b101;  4: rf3 = 3'b110;  default: rf3 = 3'b111;
                endcase
                ins = {imm[11:5], rs2, rs1, rf3, imm[4:0], 7'b1100011};
                e = mk((j < 2) ? 4'b1000 : (j < 4) ? 4'b0010 : 4'b1010, 0, 2'b00, 1, rf3, 0);
            end
            26: begin
                op = ($urandom_range(0, 1) == 0) ? 7'b0001111 : 7'b1110011;
                ins = {imm, rs1, rf3, rd, op}; e = mk(4'b0000, 0, 2'b00, 0, 0, 0);
            end
            default: begin
                op = 7'($urandom);
                if ($urandom_range(0, 1) == 0) op[1:0] = 2'b00;
                else op = 7'b0001011;
                ins = {imm, rs1, rf3, rd, op}; e = mk(4'b0000, 0, 2'b00, 0, 0, c_ill_en);
            end
        endcase
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("ALUCtl",    32'(bus.ALUCtl),    32'(m_item.ctl));
            chk("ALUASrc",   32'(bus.ALUASrc),   32'(m_item.a));
            chk("ALUBSrc",   32'(bus.ALUBSrc),   32'(m_item.b));
            chk("is_branch", 32'(bus.is_branch), 32'(m_item.br));
            chk("pc_out",    bus.pc_out,         m_item.pc);
            chk("illegal",   32'(bus.illegal),   32'(m_item.ill));
            if (m_item.br)
                chk("br_funct3", 32'(bus.br_funct3), 32'(m_item.f3));
        end
    endtask

    // One clock: drive at the negedge, check in_ready, advance the slot model, check outputs.
    task automatic step(input logic fl, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic ordy, input item_t e);
        item_t ep = e;
        ep.pc = pc;
        bus.flush = fl; bus.in_valid = iv; bus.instr = ins; bus.pc_in = pc; bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
        @(posedge clk);
        if (fl)
            m_valid = 1'b0;
        else if (!m_valid || ordy) begin
            m_valid = iv;
            if (iv) m_item = ep;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        logic [31:0] ins;
        item_t e;
        item_t e_add, e_sltiu, e_srai, e_jal, e_beq, e_nop, e_bad;
        e_add   = mk(4'b0000, 0, 2'b00, 0, 3'b000, 0);
        e_sltiu = mk(4'b1010, 0, 2'b01, 0, 3'b000, 0);
        e_srai  = mk(4'b1101, 0, 2'b01, 0, 3'b000, 0);
        e_jal   = mk(4'b0000, 1, 2'b10, 0, 3'b000, 0);
        e_beq   = mk(4'b1000, 0, 2'b00, 1, 3'b000, 0);
        e_nop   = mk(4'b0000, 0, 2'b00, 0, 3'b000, 0);
        e_bad   = mk(4'b0000, 0, 2'b00, 0, 3'b000, c_ill_en);

        rst = 1'b1;
        bus.flush = 0; bus.in_valid = 0; bus.instr = '0; bus.pc_in = '0; bus.out_ready = 0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_ALUCtl",    32'(bus.ALUCtl),    0);
        chk("rst_ALUBSrc",   32'(bus.ALUBSrc),   0);
        chk("rst_pc_out",    bus.pc_out,         0);
        chk("rst_illegal",   32'(bus.illegal),   0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        step(0, 1, 32'h002081B3, 32'h100, 1, e_add);
        step(0, 1, 32'h0010B193, 32'h104, 1, e_sltiu);
        step(0, 1, 32'h4040D193, 32'h108, 1, e_srai);
        step(0, 1, 32'h008000EF, 32'h10C, 1, e_jal);
        step(0, 1, 32'h00208463, 32'h110, 1, e_beq);
        step(0, 1, 32'h0000007F, 32'h114, 1, e_bad);
        step(0, 0, 32'h0,        32'h0,   1, e_nop);

        // Stall with the next instruction waiting, then release.
        step(0, 1, 32'h002081B3, 32'h200, 1, e_add);
        for (int i = 0; i < 3; i++)
            step(0, 1, 32'h00208463, 32'h204, 0, e_beq);
        step(0, 1, 32'h00208463, 32'h204, 1, e_beq);
        step(0, 0, 32'h0,        32'h0,   1, e_nop);

        // Flush with input offered, and flush during a stall.
        step(0, 1, 32'h008000EF, 32'h300, 1, e_jal);
        step(1, 1, 32'h002081B3, 32'h304, 1, e_add);
        step(0, 1, 32'h0010B193, 32'h308, 1, e_sltiu);
        step(1, 0, 32'h0,        32'h0,   0, e_nop);

        // Asynchronous reset in the middle of a stall.
        step(0, 1, 32'h4040D193, 32'h400, 1, e_srai);
        bus.in_valid = 0; bus.out_ready = 0;
        #2 rst = 1'b1;
        #1;
        chk("amid_out_valid", 32'(bus.out_valid), 0);
        chk("amid_ALUCtl",    32'(bus.ALUCtl),    0);
        chk("amid_ALUBSrc",   32'(bus.ALUBSrc),   0);
        chk("amid_pc_out",    bus.pc_out,         0);
        #1 rst = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        check_outputs();

        for (int i = 0; i < 600; i++) begin
            gen(ins, e);
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, ins,
                 $urandom, $urandom_range(0, 3) != 0, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
